// File: rtl/ft232h_asynfifo_rw.sv
`default_nettype none
// ============================================================================
// Module      : ft232h_asynfifo_rw
// Description : FT232H 245 asynchronous FIFO bridge, half-duplex round-robin
//               read/write sequencer with a first-word-fall-through RX buffer.
// Revision    : 1.0  initial release
// ============================================================================
module ft232h_asynfifo_rw #(
   parameter int RD_PULSE = 2,
   parameter int RD_RECOV = 1,
   parameter int WR_PULSE = 2,
   parameter int WR_RECOV = 1,
   parameter int RX_DEPTH = 4,
   localparam int RX_AW   = $clog2(RX_DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_rxf_n,
   input  logic          i_txe_n,
   input  logic [7:0]    i_ft_data,
   output logic [7:0]    o_ft_data,
   output logic          o_ft_oe,
   output logic          o_rd_n,
   output logic          o_wr_n,
   output logic [7:0]    o_rx_data,
   output logic          o_rx_valid,
   input  logic          i_rx_ready,
   input  logic [7:0]    i_tx_data,
   input  logic          i_tx_valid,
   output logic          o_tx_ready,
   output logic [RX_AW:0] o_rx_count
);

   localparam int MAXC_A = (RD_PULSE > RD_RECOV) ? RD_PULSE : RD_RECOV;
   localparam int MAXC_B = (WR_PULSE > WR_RECOV) ? WR_PULSE : WR_RECOV;
   localparam int MAXC   = (MAXC_A > MAXC_B) ? MAXC_A : MAXC_B;
   localparam int CW     = (MAXC <= 2) ? 1 : $clog2(MAXC);
   localparam logic [RX_AW:0] DEPTH_V = (RX_AW+1)'(RX_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RD_STROBE = 3'd1,
      S_RD_RECOV  = 3'd2,
      S_WR_SETUP  = 3'd3,
      S_WR_STROBE = 3'd4,
      S_WR_RECOV  = 3'd5
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              prefer_rd;
   logic              rd_elig;
   logic              wr_elig;
   logic              grant_rd;
   logic              grant_wr;
   logic              push;
   logic              pop;
   logic [7:0]        mem [RX_DEPTH];
   logic [RX_AW-1:0]  wr_ptr;
   logic [RX_AW-1:0]  rd_ptr;
   logic [RX_AW:0]    count;

   // Arbitration: a read is only eligible if the buffer has room, which
   // reserves the slot for the byte that read will push.
   always_comb begin
      rd_elig  = !i_rxf_n && (count < DEPTH_V);
      wr_elig  = i_tx_valid && !i_txe_n;
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (state == S_IDLE && !i_rst) begin
         grant_rd = rd_elig && (!wr_elig || prefer_rd);
         grant_wr = wr_elig && !grant_rd;
      end
   end

   assign o_tx_ready = grant_wr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         prefer_rd <= 1'b1;
         o_rd_n    <= 1'b1;
         o_wr_n    <= 1'b1;
         o_ft_oe   <= 1'b0;
         o_ft_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_rd) begin
                  state     <= S_RD_STROBE;
                  o_rd_n    <= 1'b0;
                  cnt       <= CW'(RD_PULSE - 1);
                  prefer_rd <= 1'b0;
               end else if (grant_wr) begin
                  state     <= S_WR_SETUP;
                  o_ft_data <= i_tx_data;
                  o_ft_oe   <= 1'b1;
                  prefer_rd <= 1'b1;
               end
            end
            S_RD_STROBE: begin
               if (cnt == '0) begin
                  state  <= S_RD_RECOV;
                  o_rd_n <= 1'b1;
                  cnt    <= CW'(RD_RECOV - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RD_RECOV: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            S_WR_SETUP: begin
               state  <= S_WR_STROBE;
               o_wr_n <= 1'b0;
               cnt    <= CW'(WR_PULSE - 1);
            end
            S_WR_STROBE: begin
               if (cnt == '0) begin
                  state  <= S_WR_RECOV;
                  o_wr_n <= 1'b1;
                  cnt    <= CW'(WR_RECOV - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_WR_RECOV: begin
               if (cnt == '0) begin
                  state   <= S_IDLE;
                  o_ft_oe <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The bus is sampled at the edge that ends the final strobe cycle.
   assign push = (state == S_RD_STROBE) && (cnt == '0) && !i_rst;
   assign pop  = i_rx_ready && (count != '0);

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_ft_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign o_rx_data  = mem[rd_ptr];
   assign o_rx_valid = (count != '0);
   assign o_rx_count = count;

endmodule
`default_nettype wire

// File: doc/ft232h_asynfifo_rw.md
FT232H_ASYNFIFO_RW -- requirements
Module: ft232h_asynfifo_rw

Interface
REQ-001 Parameter RD_PULSE, default 2: cycles RD# held low per read (>=1).
REQ-002 Parameter RD_RECOV, default 1: cycles RD# held high after a read before next grant (>=1).
REQ-003 Parameter WR_PULSE, default 2: cycles WR# held low per write (>=1).
REQ-004 Parameter WR_RECOV, default 1: cycles WR# high, bus still driven, after a write (>=1).
REQ-005 Parameter RX_DEPTH, default 4: receive buffer entries, power of two >=2; RX_AW = log2(RX_DEPTH).
REQ-006 i_clk  in  1  single system clock, all logic on rising edge.
REQ-007 i_rst  in  1  reset; synchronous, active-high.
REQ-008 i_rxf_n  in  1  FT232H RXF#, low = data available.
REQ-009 i_txe_n  in  1  FT232H TXE#, low = space for a write.
REQ-010 i_ft_data  in  8  FT232H data bus, input side.
REQ-011 o_ft_data  out  8  FT232H data bus, output side.
REQ-012 o_ft_oe  out  1  high = drive o_ft_data onto the pad.
REQ-013 o_rd_n  out  1  FT232H RD#.
REQ-014 o_wr_n  out  1  FT232H WR#.
REQ-015 o_rx_data  out  8  head of receive buffer.
REQ-016 o_rx_valid  out  1  receive buffer not empty.
REQ-017 i_rx_ready  in  1  consumer pops head when high with o_rx_valid.
REQ-018 i_tx_data  in  8  byte to transmit.
REQ-019 i_tx_valid  in  1  transmit byte offered.
REQ-020 o_tx_ready  out  1  transmit byte accepted this cycle when high with i_tx_valid.
REQ-021 o_rx_count  out  RX_AW+1  receive buffer occupancy.

Function
REQ-022 FSM states SHALL be IDLE, RD_STROBE, RD_RECOV, WR_SETUP, WR_STROBE, WR_RECOV; one transfer in flight at a time (half-duplex).
REQ-023 In IDLE, read is eligible when i_rxf_n=0 and o_rx_count<RX_DEPTH; write is eligible when i_tx_valid=1 and i_txe_n=0.
REQ-024 If only one is eligible it is granted; if both, grant the one not served last (round-robin flag; read wins after reset).
REQ-025 Read grant: next state RD_STROBE; o_rd_n low starting the cycle after grant for exactly RD_PULSE cycles.
REQ-026 i_ft_data SHALL be sampled and pushed into the receive buffer on the last RD_STROBE cycle.
REQ-027 Then RD_RECOV with o_rd_n high for RD_RECOV cycles, then IDLE; i_rxf_n ignored outside IDLE.
REQ-028 Write grant: o_tx_ready is combinationally high in the IDLE cycle of grant only; i_tx_data captured into o_ft_data on that edge.
REQ-029 WR_SETUP lasts 1 cycle with o_ft_oe=1, o_wr_n=1; WR_STROBE holds o_wr_n low WR_PULSE cycles; WR_RECOV holds o_wr_n=1, o_ft_oe=1 for WR_RECOV cycles; then IDLE with o_ft_oe=0.
REQ-030 o_ft_oe SHALL be 0 in every read state; o_ft_data holds last written byte when idle.
REQ-031 o_tx_ready SHALL be 0 in every non-IDLE state and whenever write is not granted.
REQ-032 Receive buffer: first-word-fall-through; o_rx_data valid whenever o_rx_valid=1; pop on i_rx_ready & o_rx_valid.
REQ-033 Simultaneous push and pop: count unchanged, both take effect, order preserved; pop on empty ignored.
REQ-034 Read grant reserves space, so push never occurs on full; pointers wrap modulo RX_DEPTH.
REQ-035 Minimum read cycle = 1+RD_PULSE+RD_RECOV clocks; minimum write cycle = 1+1+WR_PULSE+WR_RECOV clocks.

Reset
REQ-036 While i_rst=1 at an edge: state IDLE, o_rd_n=1, o_wr_n=1, o_ft_oe=0, o_ft_data=0, o_tx_ready=0, buffer flushed (o_rx_valid=0, o_rx_count=0), round-robin flag = read.
REQ-037 Reset mid-strobe SHALL abort the transfer; partially read byte is discarded; RD#/WR# high from the first reset edge.

Verification
REQ-038 Defaults, i_rxf_n=0, i_ft_data=0xA5, i_rx_ready=0 -> o_rd_n low exactly 2 cycles per read, 4 reads of 0xA5 buffered, o_rx_count=4, no 5th RD# pulse.
REQ-039 Buffer full, then pulse i_rx_ready one cycle -> count 3, next read begins in following IDLE, count back to 4.
REQ-040 i_tx_valid=1, i_tx_data=0x3C, i_txe_n=0 -> o_tx_ready 1 cycle, o_ft_oe high 4 cycles, o_wr_n low 2 cycles with o_ft_data=0x3C.
REQ-041 i_rxf_n=0 and i_tx_valid=1 continuously -> transfers alternate read, write, read, write.
REQ-042 Assert i_rst during second RD_STROBE cycle -> o_rd_n=1 next edge, o_rx_count=0, no byte delivered.
REQ-043 Simultaneous push and pop at count 2 with RX_DEPTH=4 -> count stays 2, output order matches input order across pointer wrap.
